serial_rx_8051: RTL
===================

Name: serial_rx_8051

Overview:
- 8051 serial-port mode-1 receiver: 8N1 asynchronous frames arrive on an input pin and are loaded into an SBUF-style register.
- Raises the RI flag on a good frame and drives a level interrupt request into interrupt_control, alongside the existing timer and external-interrupt sources.
- Input-direction counterpart of the parallel P1 output path; bit timing comes from a fixed clock divider.

Parameters:
- BAUD_DIV, 104, clock cycles per bit (even, >=4).
- CNT_W, 8, bit-counter width; must hold BAUD_DIV-1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rxd  in  1  serial input pin, asynchronous, idle high
- ren  in  1  receive enable (SCON.REN)
- ri_clr  in  1  one-cycle pulse from software SFR write; clears ri_flag, fe_flag, ovr_flag
- sbuf  out  8  last good received byte
- ri_flag  out  1  receive-complete flag (SCON.RI)
- int_ri  out  1  interrupt request to interrupt_control; equals ri_flag
- fe_flag  out  1  framing error: stop bit sampled 0
- ovr_flag  out  1  overrun: good frame arrived while ri_flag=1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high) values:
  - sbuf=0x00; ri_flag, fe_flag, ovr_flag, busy = 0.
  - State=IDLE, counters=0, synchronizer flops=1.
  - Reset mid-frame aborts the frame with no flag or sbuf update.
- Synchronizer: rxd passes through 2 flops to give rxd_s. rxd_s lags rxd by 2 cycles; only rxd_s is used internally.
- States: IDLE, START, DATA, STOP.
- IDLE: when ren=1 and rxd_s falls (previous 1, now 0): go to START, cnt=0.
  - A line held low, e.g. after a framing error, does not start a frame until it returns high.
- START: cnt counts. At cnt==BAUD_DIV/2-1, sample rxd_s:
  - 0: go to DATA, cnt=0, bitidx=0.
  - 1: false start; go to IDLE, no flag change.
- DATA: at cnt==BAUD_DIV-1, shift rxd_s into shreg LSB-first, cnt=0, bitidx++. After bit 7, go to STOP.
- STOP: at cnt==BAUD_DIV-1, sample rxd_s and go to IDLE.
  - Sample 1 and ri_flag=0: sbuf<=shreg, ri_flag<=1.
  - Sample 1 and ri_flag=1: sbuf unchanged, ovr_flag<=1.
  - Sample 0: fe_flag<=1, sbuf and ri_flag unchanged.
- Timing, with edge E = first edge at which IDLE sees rxd_s low:
  - Start sample at E+BAUD_DIV/2.
  - Data bit i sampled at E+BAUD_DIV/2+(i+1)*BAUD_DIV.
  - Stop sample at E+BAUD_DIV/2+9*BAUD_DIV.
  - sbuf, ri_flag and fe/ovr updates are visible after that stop-sample edge.
  - A new falling edge is accepted from the cycle after returning to IDLE.
- ren=0 in any non-IDLE state: immediate return to IDLE next edge; frame discarded, flags unchanged. ren=0 does not clear flags.
- ri_clr:
  - Clears ri_flag, fe_flag, ovr_flag next edge.
  - Coincident with a set event, set wins: the flag is 1 after that edge.
  - Does not affect reception in progress.
- int_ri is a pure level copy of ri_flag. interrupt_control owns priority and latching; this block has no ack input.
- Counters wrap only by explicit reload; no free-running wrap.
- shreg is not observable outside the block.

Test Plan:
- Good frame: BAUD_DIV=16, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> busy high during frame; sbuf=0xA5 and ri_flag=int_ri=1 after stop sample at E+152; fe_flag=ovr_flag=0.
- Glitch: rxd low for 4 clocks, then high -> START returns to IDLE at E+8; no flag change; sbuf unchanged.
- Overrun: frames 0x3C then 0xC3, no ri_clr -> sbuf=0x3C, ri_flag=1, ovr_flag=1. After ri_clr pulse, all flags 0 and sbuf still 0x3C.
- Framing error: 0x55 with stop bit driven 0, then line held low -> fe_flag=1, ri_flag=0, sbuf unchanged, no new frame. Line high, then frame 0x12 -> sbuf=0x12, ri_flag=1.
- Abort: ren dropped at bit 4 of 0xFF frame -> IDLE next edge, busy=0, no flags set. Reset asserted mid-frame -> all outputs at reset values.
- Coincidence: ri_clr pulsed on the stop-sample edge of good frame 0x81 -> ri_flag=1, sbuf=0x81.

Source files
------------

// File: rtl/serial_rx_8051.sv
// 8051 serial-port mode-1 receiver: 8N1 frames on rxd are loaded into sbuf.
// Raises ri_flag (mirrored on int_ri) on a good frame; tracks framing and overrun errors.
module serial_rx_8051 #(
  parameter int BAUD_DIV = 104,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ren,
  input  logic       ri_clr,
  output logic [7:0] sbuf,
  output logic       ri_flag,
  output logic       int_ri,
  output logic       fe_flag,
  output logic       ovr_flag,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             rxd_m_q, rxd_s_q, rxd_p_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitidx_q, bitidx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       sbuf_q, sbuf_d;
  logic             ri_q, ri_d;
  logic             fe_q, fe_d;
  logic             ovr_q, ovr_d;
  logic             busy_q;
  logic             fall_s;
  logic             stop_ok_s;
  logic             stop_bad_s;
  logic             load_s;

  // rxd_p_q holds the previous synchronized level so only a 1->0 transition starts a frame
  assign fall_s = rxd_p_q & ~rxd_s_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ren && fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (!ren) begin
          state_d = ST_IDLE;
        end else if (cnt_q == HALF_M1) begin
          state_d = rxd_s_q ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (!ren) begin
          state_d = ST_IDLE;
        end else if ((cnt_q == FULL_M1) && (bitidx_q == 3'd7)) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (!ren) begin
          state_d = ST_IDLE;
        end else if (cnt_q == FULL_M1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    bitidx_d   = bitidx_q;
    shreg_d    = shreg_q;
    stop_ok_s  = 1'b0;
    stop_bad_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        bitidx_d = 3'd0;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d    = '0;
          bitidx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          bitidx_d = bitidx_q + 3'd1;
          shreg_d  = {rxd_s_q, shreg_q[7:1]};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          stop_ok_s  = ren & rxd_s_q;
          stop_bad_s = ren & ~rxd_s_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d    = '0;
        bitidx_d = 3'd0;
      end
    endcase
  end

  // A set event on the stop-sample edge overrides a coincident ri_clr
  always_comb begin
    load_s = stop_ok_s & ~ri_q;
    sbuf_d = load_s ? shreg_q : sbuf_q;
    ri_d   = load_s | (ri_q & ~ri_clr);
    ovr_d  = (stop_ok_s & ri_q) | (ovr_q & ~ri_clr);
    fe_d   = stop_bad_s | (fe_q & ~ri_clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_m_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      rxd_p_q  <= 1'b1;
      cnt_q    <= '0;
      bitidx_q <= 3'd0;
      shreg_q  <= 8'h00;
      sbuf_q   <= 8'h00;
      ri_q     <= 1'b0;
      fe_q     <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rxd_m_q  <= rxd;
      rxd_s_q  <= rxd_m_q;
      rxd_p_q  <= rxd_s_q;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
      sbuf_q   <= sbuf_d;
      ri_q     <= ri_d;
      fe_q     <= fe_d;
      ovr_q    <= ovr_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign sbuf     = sbuf_q;
  assign ri_flag  = ri_q;
  assign int_ri   = ri_q;
  assign fe_flag  = fe_q;
  assign ovr_flag = ovr_q;
  assign busy     = busy_q;

endmodule
